pkt_fifo: RTL and testbench

//  Parametrised packet-aware FIFO, successor of the plain byte FIFO. Buffers pBITS words with an
//  end-of-packet marker; words become visible to the reader only once their packet is committed
//  by iw_last. A packet can be discarded by the writer or dropped on overflow. Sits between the

---
 rtl/pkt_fifo_pkg.sv | 16 +
 rtl/pkt_fifo_ram.sv | 29 ++
 rtl/pkt_fifo.sv | 179 +++++++++++++++++
 tb/tb_pkt_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the packet-aware FIFO.
package pkt_fifo_pkg;

  // Write-side packet state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PKT     = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  // Address width for a storage depth; pointers carry one extra wrap bit.
  function automatic int f_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Each entry holds {last, data}. Contents are intentionally not reset.
module pkt_fifo_ram
  import pkt_fifo_pkg::*;
#(
  parameter int pBITS  = 8,
  parameter int pDEPTH = 16,
  localparam int AW    = f_aw(pDEPTH)
) (
  input  logic          iclk,
  input  logic          iwe,
  input  logic [AW-1:0] iwaddr,
  input  logic [pBITS:0] iwdata,
  input  logic [AW-1:0] iraddr,
  output logic [pBITS:0] ordata
);

  logic [pBITS:0] mem_q [pDEPTH];

  // Store one word per write strobe.
  always_ff @(posedge iclk) begin
    if (iwe) begin
      mem_q[iwaddr] <= iwdata;
    end
  end

  assign ordata = mem_q[iraddr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet-aware FIFO: words are written speculatively and only become
// visible to the reader once the packet's last word commits it. Packets can
// be discarded by the writer or are dropped whole when storage runs out.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int pBITS   = 8,
  parameter int pDEPTH  = 16,
  parameter int pAFULL  = pDEPTH - 2,
  parameter int pAEMPTY = 2,
  localparam int AW     = f_aw(pDEPTH)
) (
  input  logic             iclk,
  input  logic             ireset_n,
  input  logic             iwr,
  input  logic [pBITS-1:0] iw_data,
  input  logic             iw_last,
  input  logic             iw_drop,
  output logic             ofull,
  output logic             oafull,
  input  logic             ird,
  output logic             or_valid,
  output logic [pBITS-1:0] or_data,
  output logic             or_last,
  output logic             oempty,
  output logic             oaempty,
  output logic [AW:0]      olevel,
  output logic [AW:0]      opkt_cnt,
  output logic             ooverflow
);

  localparam int PW = AW + 1;
  localparam logic [AW:0] ONE_C    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_C  = PW'(pDEPTH);
  localparam logic [AW:0] AFULL_C  = PW'(pAFULL);
  localparam logic [AW:0] AEMPTY_C = PW'(pAEMPTY);

  // Reject unsupported geometries at elaboration.
  if ((pDEPTH < 4) || ((pDEPTH & (pDEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pkt_fifo: pDEPTH must be a power of 2 and >= 4");
  end
  if (pAFULL > pDEPTH) begin : g_bad_afull
    $error("pkt_fifo: pAFULL must not exceed pDEPTH");
  end

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [AW:0]    wr_q, wr_d;      // speculative write pointer
  logic [AW:0]    cm_q, cm_d;      // committed boundary
  logic [AW:0]    rd_q, rd_d;      // read pointer
  logic [AW:0]    pkt_cnt_q, pkt_cnt_d;
  wr_state_e      st_q, st_d;
  logic           ovf_q, ovf_d;

  logic [AW:0]    occ_s;
  logic [AW:0]    level_s;
  logic           full_s;
  logic           valid_s;
  logic           pop_s;
  logic           we_s;
  logic           commit_s;
  logic [pBITS:0] rd_word_s;

  assign occ_s   = wr_q - rd_q;
  assign level_s = cm_q - rd_q;
  assign full_s  = (occ_s == DEPTH_C);
  assign valid_s = (cm_q != rd_q);
  assign pop_s   = ird & valid_s;

  pkt_fifo_ram #(
    .pBITS  (pBITS),
    .pDEPTH (pDEPTH)
  ) u_ram (
    .iclk   (iclk),
    .iwe    (we_s),
    .iwaddr (wr_q[AW-1:0]),
    .iwdata ({iw_last, iw_data}),
    .iraddr (rd_q[AW-1:0]),
    .ordata (rd_word_s)
  );

  // Write-side packet FSM: store, commit, discard and overflow decisions.
  always_comb begin
    wr_d     = wr_q;
    cm_d     = cm_q;
    st_d     = st_q;
    ovf_d    = 1'b0;
    we_s     = 1'b0;
    commit_s = 1'b0;
    if (iw_drop) begin
      wr_d = cm_q;
      st_d = ST_IDLE;
    end else if (iwr) begin
      case (st_q)
        ST_IDLE, ST_PKT: begin
          if (!full_s) begin
            we_s = 1'b1;
            wr_d = wr_q + ONE_C;
            if (iw_last) begin
              cm_d     = wr_q + ONE_C;
              commit_s = 1'b1;
              st_d     = ST_IDLE;
            end else begin
              st_d = ST_PKT;
            end
          end else begin
            // No room: rewind to the committed boundary, drop the packet.
            wr_d  = cm_q;
            ovf_d = 1'b1;
            if (iw_last) begin
              st_d = ST_IDLE;
            end else begin
              st_d = ST_DISCARD;
            end
          end
        end
        ST_DISCARD: begin
          if (iw_last) begin
            st_d = ST_IDLE;
          end else begin
            st_d = ST_DISCARD;
          end
        end
        default: begin
          wr_d = cm_q;
          st_d = ST_IDLE;
        end
      endcase
    end else begin
      st_d = st_q;
    end
  end

  // Read pointer and complete-packet count.
  always_comb begin
    rd_d      = rd_q;
    pkt_cnt_d = pkt_cnt_q;
    if (pop_s) begin
      rd_d = rd_q + ONE_C;
    end else begin
      rd_d = rd_q;
    end
    case ({commit_s, pop_s & rd_word_s[pBITS]})
      2'b10:   pkt_cnt_d = pkt_cnt_q + ONE_C;
      2'b01:   pkt_cnt_d = pkt_cnt_q - ONE_C;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      wr_q      <= {PW{1'b0}};
      cm_q      <= {PW{1'b0}};
      rd_q      <= {PW{1'b0}};
      pkt_cnt_q <= {PW{1'b0}};
      st_q      <= ST_IDLE;
      ovf_q     <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      cm_q      <= cm_d;
      rd_q      <= rd_d;
      pkt_cnt_q <= pkt_cnt_d;
      st_q      <= st_d;
      ovf_q     <= ovf_d;
    end
  end

  assign or_valid  = valid_s;
  assign or_data   = valid_s ? rd_word_s[pBITS-1:0] : {pBITS{1'b0}};
  assign or_last   = valid_s & rd_word_s[pBITS];
  assign oempty    = ~valid_s;
  assign ofull     = full_s;
  assign oafull    = (occ_s >= AFULL_C);
  assign oaempty   = (level_s <= AEMPTY_C);
  assign olevel    = level_s;
  assign opkt_cnt  = pkt_cnt_q;
  assign ooverflow = ovf_q;

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo with a scoreboard: stimulus pushes expected
// {last,data} words, an independent monitor compares every pop.
module tb_pkt_fifo;

  localparam int BITS = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             ireset_n = 1'b0;
  logic             iwr = 1'b0;
  logic [BITS-1:0]  iw_data = 8'h00;
  logic             iw_last = 1'b0;
  logic             iw_drop = 1'b0;
  logic             ird = 1'b0;
  logic             ofull, oafull, or_valid, or_last, oempty, oaempty, ooverflow;
  logic [BITS-1:0]  or_data;
  logic [AW:0]      olevel, opkt_cnt;

  int checks = 0;
  int failures = 0;
  logic [BITS:0] exp_q [$];

  pkt_fifo #(.pBITS(BITS), .pDEPTH(DEPTH), .pAFULL(14), .pAEMPTY(2)) dut (
    .iclk(clk), .ireset_n(ireset_n), .iwr(iwr), .iw_data(iw_data),
    .iw_last(iw_last), .iw_drop(iw_drop), .ofull(ofull), .oafull(oafull),
    .ird(ird), .or_valid(or_valid), .or_data(or_data), .or_last(or_last),
    .oempty(oempty), .oaempty(oaempty), .olevel(olevel), .opkt_cnt(opkt_cnt),
    .ooverflow(ooverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [7:0] d, input logic last, input logic expect_out);
    iwr = 1'b1;
    iw_data = d;
    iw_last = last;
    if (expect_out) exp_q.push_back({last, d});
    tick();
    iwr = 1'b0;
    iw_last = 1'b0;
  endtask

  // Monitor: every accepted pop must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ireset_n && or_valid && ird) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {23'd0, or_last, or_data}, 32'h1ff);
      end else begin
        logic [BITS:0] e;
        e = exp_q.pop_front();
        chk("pop_data", {24'd0, or_data}, {24'd0, e[BITS-1:0]});
        chk("pop_last", {31'd0, or_last}, {31'd0, e[BITS]});
      end
    end else if (ireset_n && !or_valid) begin
      chk("idle_data_zero", {23'd0, or_last, or_data}, 32'd0);
    end
  end

  initial begin
    int ovf_cnt;

    // Reset with write strobe active: nothing must be stored.
    ireset_n = 1'b0; iwr = 1'b1; iw_data = 8'h55; iw_last = 1'b1;
    tick(); tick();
    chk("rst_or_valid", {31'd0, or_valid}, 32'd0);
    chk("rst_oempty", {31'd0, oempty}, 32'd1);
    chk("rst_ofull", {31'd0, ofull}, 32'd0);
    chk("rst_oafull", {31'd0, oafull}, 32'd0);
    chk("rst_oaempty", {31'd0, oaempty}, 32'd1);
    chk("rst_olevel", {27'd0, olevel}, 32'd0);
    chk("rst_opkt_cnt", {27'd0, opkt_cnt}, 32'd0);
    chk("rst_ooverflow", {31'd0, ooverflow}, 32'd0);
    iwr = 1'b0; iw_last = 1'b0; ireset_n = 1'b1;
    tick();
    chk("post_rst_olevel", {27'd0, olevel}, 32'd0);
    chk("post_rst_valid", {31'd0, or_valid}, 32'd0);

    // Three-word packet becomes visible only after its last word.
    wr_word(8'hA1, 1'b0, 1'b1);
    chk("p3_hidden1", {31'd0, or_valid}, 32'd0);
    wr_word(8'hA2, 1'b0, 1'b1);
    chk("p3_hidden2", {31'd0, or_valid}, 32'd0);
    wr_word(8'hA3, 1'b1, 1'b1);
    chk("p3_visible", {31'd0, or_valid}, 32'd1);
    chk("p3_level", {27'd0, olevel}, 32'd3);
    chk("p3_pkt_cnt", {27'd0, opkt_cnt}, 32'd1);
    chk("p3_aempty_lvl3", {31'd0, oaempty}, 32'd0);
    ird = 1'b1;
    tick();
    chk("p3_level2", {27'd0, olevel}, 32'd2);
    chk("p3_aempty_lvl2", {31'd0, oaempty}, 32'd1);
    tick(); tick();
    ird = 1'b0;
    chk("p3_pkt_cnt0", {27'd0, opkt_cnt}, 32'd0);
    chk("p3_empty", {31'd0, oempty}, 32'd1);

    // Writer discard: five words then drop (drop beats a simultaneous last).
    for (int i = 0; i < 5; i++) wr_word(8'(8'h20 + i), 1'b0, 1'b0);
    chk("drop_pre_level", {27'd0, olevel}, 32'd0);
    chk("drop_pre_valid", {31'd0, or_valid}, 32'd0);
    iw_drop = 1'b1; iwr = 1'b1; iw_data = 8'h99; iw_last = 1'b1;
    tick();
    iw_drop = 1'b0; iwr = 1'b0; iw_last = 1'b0;
    chk("drop_level", {27'd0, olevel}, 32'd0);
    chk("drop_pkt_cnt", {27'd0, opkt_cnt}, 32'd0);
    wr_word(8'h10, 1'b0, 1'b1);
    wr_word(8'h11, 1'b1, 1'b1);
    chk("after_drop_level", {27'd0, olevel}, 32'd2);
    ird = 1'b1; tick(); tick(); ird = 1'b0;
    chk("after_drop_empty", {31'd0, oempty}, 32'd1);

    // Almost-full threshold and full; a stale drop would push this earlier.
    for (int i = 0; i < 13; i++) wr_word(8'(8'h30 + i), 1'b0, 1'b1);
    chk("afull_occ13", {31'd0, oafull}, 32'd0);
    wr_word(8'h3D, 1'b0, 1'b1);
    chk("afull_occ14", {31'd0, oafull}, 32'd1);
    chk("afull_not_full", {31'd0, ofull}, 32'd0);
    wr_word(8'h3E, 1'b0, 1'b1);
    wr_word(8'h3F, 1'b1, 1'b1);
    chk("full16", {31'd0, ofull}, 32'd1);
    chk("full_level", {27'd0, olevel}, 32'd16);
    // Write while full is refused even though a pop happens the same cycle.
    ird = 1'b1;
    wr_word(8'hEE, 1'b1, 1'b0);
    chk("full_refused_ovf", {31'd0, ooverflow}, 32'd1);
    chk("full_refused_level", {27'd0, olevel}, 32'd15);
    chk("full_refused_cnt", {27'd0, opkt_cnt}, 32'd1);
    tick();
    chk("ovf_one_cycle", {31'd0, ooverflow}, 32'd0);
    for (int i = 0; i < 14; i++) tick();
    ird = 1'b0;
    chk("full_drained", {31'd0, oempty}, 32'd1);
    chk("full_drained_cnt", {27'd0, opkt_cnt}, 32'd0);

    // Oversized packet: 20 words with no reads.
    ovf_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      wr_word(8'(8'h40 + i), (i == 19), 1'b0);
      if (i == 15) begin
        chk("big_full_at16", {31'd0, ofull}, 32'd1);
        chk("big_hidden", {31'd0, or_valid}, 32'd0);
      end
      if (i >= 15) ovf_cnt += int'(ooverflow);
    end
    chk("big_ovf_pulses", ovf_cnt, 32'd1);
    chk("big_empty", {31'd0, oempty}, 32'd1);
    chk("big_not_full", {31'd0, ofull}, 32'd0);
    wr_word(8'h50, 1'b0, 1'b1);
    wr_word(8'h51, 1'b1, 1'b1);
    chk("big_next_level", {27'd0, olevel}, 32'd2);
    ird = 1'b1; tick(); tick(); ird = 1'b0;
    chk("big_next_empty", {31'd0, oempty}, 32'd1);

    // Streaming 4-word packets with continuous reads; wraps pointers.
    ird = 1'b1;
    for (int p = 0; p < 28; p++) begin
      for (int w = 0; w < 4; w++) wr_word(8'(8'h80 + p * 4 + w), (w == 3), 1'b1);
      chk("stream_pkt_cnt", {27'd0, opkt_cnt}, 32'd1);
      chk("stream_level", {27'd0, olevel}, 32'd4);
    end
    for (int i = 0; i < 6; i++) tick();
    ird = 1'b0;
    chk("stream_empty", {31'd0, oempty}, 32'd1);
    chk("stream_pkt_cnt0", {27'd0, opkt_cnt}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
